// File: rtl/nms_pkg.sv
// Shared definitions for the NMS 3x3 window fetch block.
// Contents: default frame geometry, neighbour-code constants, FSM state enum,
// first/last centre address constants and helpers.
// Optional feature macro: NMS_BORDER_ZERO_EN (scan every pixel, zero-fill
// out-of-frame neighbours instead of skipping the border).
package nms_pkg;

  localparam int unsigned IMG_W_DEF = 180;
  localparam int unsigned IMG_H_DEF = 120;

  // Neighbour codes understood by the external address calculator
  localparam logic [3:0] NB_C  = 4'd0;
  localparam logic [3:0] NB_NW = 4'd1;
  localparam logic [3:0] NB_N  = 4'd2;
  localparam logic [3:0] NB_NE = 4'd3;
  localparam logic [3:0] NB_W  = 4'd4;
  localparam logic [3:0] NB_E  = 4'd5;
  localparam logic [3:0] NB_SW = 4'd6;
  localparam logic [3:0] NB_S  = 4'd7;
  localparam logic [3:0] NB_SE = 4'd8;

  localparam int unsigned NB_NUM = 9;

  // Last centre for the default frame in each scan mode
  localparam int unsigned LAST_CENTRE_DEF    = (IMG_H_DEF - 2) * IMG_W_DEF + IMG_W_DEF - 2;
  localparam int unsigned LAST_CENTRE_BZ_DEF = IMG_W_DEF * IMG_H_DEF - 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StPresent,
    StAdvance,
    StFinish
  } nms_state_e;

  function automatic int unsigned first_centre(input int unsigned w);
`ifdef NMS_BORDER_ZERO_EN
    return 0;
`else
    return w + 1;
`endif
  endfunction

  function automatic int unsigned last_centre(input int unsigned w, input int unsigned h);
`ifdef NMS_BORDER_ZERO_EN
    return w * h - 1;
`else
    return (h - 2) * w + w - 2;
`endif
  endfunction

  // True when the neighbour selected by code lies inside the frame, given
  // which borders the centre pixel touches.
  function automatic logic nb_in_frame(input logic [3:0] code, input logic top,
                                       input logic bot, input logic lft, input logic rgt);
    logic in_frame;
    case (code)
      NB_NW:   in_frame = !(top || lft);
      NB_N:    in_frame = !top;
      NB_NE:   in_frame = !(top || rgt);
      NB_W:    in_frame = !lft;
      NB_E:    in_frame = !rgt;
      NB_SW:   in_frame = !(bot || lft);
      NB_S:    in_frame = !bot;
      NB_SE:   in_frame = !(bot || rgt);
      default: in_frame = 1'b1;
    endcase
    return in_frame;
  endfunction

endpackage

// File: rtl/nms_rd_capture.sv
// Read-return capture for the NMS window fetch.
// Delays the per-slot strobe, read enable and neighbour code by RD_LAT cycles
// so they line up with SRAM read data, then writes each returning word (or
// zero for a slot that was not read) into a 9-entry window register file.
// Ports:
//   clk, resetn    clock, synchronous active-low reset (clears pipeline and slots)
//   i_slot_vld     a FETCH slot is issued this cycle
//   i_rd_en        the slot actually reads SRAM (else it captures 0)
//   i_code         neighbour code of the slot, 0..8
//   i_rdata        SRAM read data, valid RD_LAT cycles after the read
//   o_win_data     packed window, code k at [DATA_W*k +: DATA_W]
module nms_rd_capture #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_slot_vld,
  input  logic                  i_rd_en,
  input  logic [3:0]            i_code,
  input  logic [DATA_W-1:0]     i_rdata,
  output logic [9*DATA_W-1:0]   o_win_data
);

  logic [RD_LAT-1:0] r_slot_dly;
  logic [RD_LAT-1:0] r_rd_dly;
  logic [3:0]        r_code_dly [RD_LAT];
  logic [DATA_W-1:0] r_slot      [9];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_slot_dly <= '0;
      r_rd_dly   <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) r_code_dly[i] <= '0;
    end else begin
      r_slot_dly[0] <= i_slot_vld;
      r_rd_dly[0]   <= i_rd_en;
      r_code_dly[0] <= i_code;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_slot_dly[i] <= r_slot_dly[i-1];
        r_rd_dly[i]   <= r_rd_dly[i-1];
        r_code_dly[i] <= r_code_dly[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 9; k++) r_slot[k] <= '0;
    end else if (r_slot_dly[RD_LAT-1]) begin
      for (int k = 0; k < 9; k++) begin
        if (r_code_dly[RD_LAT-1] == 4'(k)) begin
          r_slot[k] <= r_rd_dly[RD_LAT-1] ? i_rdata : '0;
        end
      end
    end
  end

  always_comb begin
    o_win_data = '0;
    for (int k = 0; k < 9; k++) o_win_data[DATA_W*k +: DATA_W] = r_slot[k];
  end

endmodule

// File: rtl/nms_window_fetch.sv
// NMS 3x3 window sequencer/reader.
// Scans the gradient-magnitude frame one centre at a time, steps the
// neighbour code through the external address calculator, reads the nine
// SRAM words and hands them downstream as one packed window (valid/ready).
// Optional feature macro: NMS_BORDER_ZERO_EN -- scan every pixel as a centre
// and zero-fill neighbours outside the frame without reading them. Default
// build skips the one-pixel border instead.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   start         pulse to begin a frame scan (ignored unless idle)
//   busy, done    scan in progress / one-cycle end-of-frame pulse
//   refAddr       centre address to the address calculator
//   regAddr       neighbour code 0..8 to the address calculator
//   sram_rd_en    read strobe (address comes from the calculator)
//   sram_rdata    read data, RD_LAT cycles after sram_rd_en
//   win_valid/win_ready/win_data/win_addr  window handshake and payload
module nms_window_fetch
  import nms_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   refAddr,
  output logic [3:0]          regAddr,
  output logic                sram_rd_en,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [9*DATA_W-1:0] win_data,
  output logic [ADDR_W-1:0]   win_addr
);

  localparam int unsigned ColW = $clog2(IMG_W);

  localparam logic [ADDR_W-1:0] FirstCentre = ADDR_W'(first_centre(IMG_W));
  localparam logic [ADDR_W-1:0] LastCentre  = ADDR_W'(last_centre(IMG_W, IMG_H));
  localparam logic [1:0]        LatInit     = 2'(RD_LAT - 1);

`ifdef NMS_BORDER_ZERO_EN
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] FirstCol = '0;
`else
  localparam logic [ColW-1:0] FirstCol = ColW'(1);
`endif

  nms_state_e        r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_ref;
  logic [3:0]        r_code;
  logic              r_rd_en;
  logic              r_slot_vld;
  logic              r_win_valid;
  logic [ADDR_W-1:0] r_win_addr;
  logic [ColW-1:0]   r_col;
  logic [1:0]        r_lat_cnt;
`ifdef NMS_BORDER_ZERO_EN
  logic [RowW-1:0]   r_row;
`endif

  logic [3:0] w_code_nxt;
  logic       w_rd_nxt;

  assign w_code_nxt = r_code + 4'd1;

  // Read strobe for the next FETCH slot: suppressed for out-of-frame neighbours.
`ifdef NMS_BORDER_ZERO_EN
  assign w_rd_nxt = nb_in_frame(w_code_nxt, r_row == '0, r_row == RowW'(IMG_H - 1),
                                r_col == '0, r_col == ColW'(IMG_W - 1));
`else
  assign w_rd_nxt = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ref       <= '0;
      r_code      <= NB_C;
      r_rd_en     <= 1'b0;
      r_slot_vld  <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_addr  <= '0;
      r_col       <= '0;
      r_lat_cnt   <= '0;
`ifdef NMS_BORDER_ZERO_EN
      r_row       <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state    <= StFetch;
            r_busy     <= 1'b1;
            r_ref      <= FirstCentre;
            r_col      <= FirstCol;
`ifdef NMS_BORDER_ZERO_EN
            r_row      <= '0;
`endif
            r_code     <= NB_C;
            r_rd_en    <= 1'b1;
            r_slot_vld <= 1'b1;
          end
        end
        StFetch: begin
          if (r_code == NB_SE) begin
            r_state    <= StDrain;
            r_code     <= NB_C;
            r_rd_en    <= 1'b0;
            r_slot_vld <= 1'b0;
            r_lat_cnt  <= LatInit;
          end else begin
            r_code  <= w_code_nxt;
            r_rd_en <= w_rd_nxt;
          end
        end
        StDrain: begin
          // Leaving here coincides with the last slot landing in the capture file.
          if (r_lat_cnt == '0) begin
            r_state     <= StPresent;
            r_win_valid <= 1'b1;
            r_win_addr  <= r_ref;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        StPresent: begin
          if (win_ready) begin
            r_state     <= StAdvance;
            r_win_valid <= 1'b0;
          end
        end
        StAdvance: begin
          if (r_ref == LastCentre) begin
            r_state <= StFinish;
            r_done  <= 1'b1;
          end else begin
            r_state    <= StFetch;
            r_code     <= NB_C;
            r_rd_en    <= 1'b1;
            r_slot_vld <= 1'b1;
`ifdef NMS_BORDER_ZERO_EN
            r_ref <= r_ref + ADDR_W'(1);
            if (r_col == ColW'(IMG_W - 1)) begin
              r_col <= '0;
              r_row <= r_row + RowW'(1);
            end else begin
              r_col <= r_col + ColW'(1);
            end
`else
            // Jump over right border and next row's left border.
            if (r_col == ColW'(IMG_W - 2)) begin
              r_ref <= r_ref + ADDR_W'(3);
              r_col <= ColW'(1);
            end else begin
              r_ref <= r_ref + ADDR_W'(1);
              r_col <= r_col + ColW'(1);
            end
`endif
          end
        end
        StFinish: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  nms_rd_capture #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_capture (
    .clk        (clk),
    .resetn     (resetn),
    .i_slot_vld (r_slot_vld),
    .i_rd_en    (r_rd_en),
    .i_code     (r_code),
    .i_rdata    (sram_rdata),
    .o_win_data (win_data)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign refAddr    = r_ref;
  assign regAddr    = r_code;
  assign sram_rd_en = r_rd_en;
  assign win_valid  = r_win_valid;
  assign win_addr   = r_win_addr;

endmodule

// File: tb/tb_nms_window_fetch.sv
module tb_nms_window_fetch;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;
`ifdef NMS_BORDER_ZERO_EN
  localparam int unsigned RD_LAT = 2;
  localparam bit          BZ     = 1'b1;
`else
  localparam int unsigned RD_LAT = 1;
  localparam bit          BZ     = 1'b0;
`endif
  localparam int W1 = 180;
  localparam int H1 = 120;
  localparam int W2 = 10;
  localparam int H2 = 6;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [71:0]       data;
  } win_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  function automatic int nb_dr(input int code);
    case (code)
      1, 2, 3: return -1;
      6, 7, 8: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int nb_dc(input int code);
    case (code)
      1, 4, 6: return -1;
      3, 5, 8: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_frame(input int centre, input int code, input int w, input int h);
    int r, c;
    r = centre / w + nb_dr(code);
    c = centre % w + nb_dc(code);
    return (r >= 0) && (r < h) && (c >= 0) && (c < w);
  endfunction

  function automatic int centre_addr(input int idx, input int w);
    if (BZ) return idx;
    return (idx / (w - 2) + 1) * w + idx % (w - 2) + 1;
  endfunction

  function automatic logic [71:0] exp_data(input int a, input int w, input int h);
    logic [71:0] d;
    d = '0;
    for (int k = 0; k < 9; k++)
      if (in_frame(a, k, w, h)) d[8*k +: 8] = 8'(a + nb_dr(k) * w + nb_dc(k));
    return d;
  endfunction

  function automatic int n_windows(input int w, input int h);
    return BZ ? w * h : (w - 2) * (h - 2);
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- DUT 1: full-size frame ----------------
  logic                d1_start = 1'b0, d1_ready = 1'b0;
  logic                d1_busy, d1_done, d1_rd_en, d1_win_valid;
  logic [ADDR_W-1:0]   d1_ref, d1_win_addr;
  logic [3:0]          d1_reg;
  logic [DATA_W-1:0]   d1_rdata;
  logic [71:0]         d1_win_data;

  nms_window_fetch #(
    .IMG_W (W1), .IMG_H (H1), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RD_LAT (RD_LAT)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (d1_start),
    .busy       (d1_busy),
    .done       (d1_done),
    .refAddr    (d1_ref),
    .regAddr    (d1_reg),
    .sram_rd_en (d1_rd_en),
    .sram_rdata (d1_rdata),
    .win_valid  (d1_win_valid),
    .win_ready  (d1_ready),
    .win_data   (d1_win_data),
    .win_addr   (d1_win_addr)
  );

  // ---------------- DUT 2: small frame for whole-scan checks ----------------
  logic                d2_start = 1'b0, d2_ready = 1'b0;
  logic                d2_busy, d2_done, d2_rd_en, d2_win_valid;
  logic [ADDR_W-1:0]   d2_ref, d2_win_addr;
  logic [3:0]          d2_reg;
  logic [DATA_W-1:0]   d2_rdata;
  logic [71:0]         d2_win_data;

  nms_window_fetch #(
    .IMG_W (W2), .IMG_H (H2), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RD_LAT (RD_LAT)
  ) u_small (
    .clk        (clk),
    .resetn     (resetn),
    .start      (d2_start),
    .busy       (d2_busy),
    .done       (d2_done),
    .refAddr    (d2_ref),
    .regAddr    (d2_reg),
    .sram_rd_en (d2_rd_en),
    .sram_rdata (d2_rdata),
    .win_valid  (d2_win_valid),
    .win_ready  (d2_ready),
    .win_data   (d2_win_data),
    .win_addr   (d2_win_addr)
  );

  // ---------------- address calculator + SRAM models (data = addr[7:0]) ----------------
  logic [7:0] d1_pipe [RD_LAT];
  logic [7:0] d2_pipe [RD_LAT];
  int d1_oob = 0;
  int d2_oob = 0;

  always @(posedge clk) begin
    d1_pipe[0] <= d1_rd_en ? 8'(int'(d1_ref) + nb_dr(int'(d1_reg)) * W1 + nb_dc(int'(d1_reg)))
                           : 8'hEE;
    d2_pipe[0] <= d2_rd_en ? 8'(int'(d2_ref) + nb_dr(int'(d2_reg)) * W2 + nb_dc(int'(d2_reg)))
                           : 8'hEE;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      d1_pipe[i] <= d1_pipe[i-1];
      d2_pipe[i] <= d2_pipe[i-1];
    end
    if (d1_rd_en && !in_frame(int'(d1_ref), int'(d1_reg), W1, H1)) d1_oob <= d1_oob + 1;
    if (d2_rd_en && !in_frame(int'(d2_ref), int'(d2_reg), W2, H2)) d2_oob <= d2_oob + 1;
  end

  assign d1_rdata = d1_pipe[RD_LAT-1];
  assign d2_rdata = d2_pipe[RD_LAT-1];

  // ---------------- scoreboards / monitors ----------------
  win_t q1[$];
  win_t q2[$];
  int d1_xfer = 0, d2_xfer = 0, d2_done_cnt = 0;
  int d1_prev = -1, d1_wrap_next = -1, d2_last = -1;
  win_t m1, m2;

  always @(negedge clk) begin
    if (resetn && d1_win_valid && d1_ready) begin
      d1_xfer++;
      if (d1_prev == (BZ ? W1 - 1 : 2 * W1 - 2)) d1_wrap_next = int'(d1_win_addr);
      d1_prev = int'(d1_win_addr);
      if (q1.size() > 0) begin
        m1 = q1.pop_front();
        chk("d1_win_addr", d1_win_addr, m1.addr);
        chk("d1_win_data", d1_win_data, m1.data);
      end
    end
    if (resetn && d2_win_valid && d2_ready) begin
      d2_xfer++;
      d2_last = int'(d2_win_addr);
      if (q2.size() > 0) begin
        m2 = q2.pop_front();
        chk("d2_win_addr", d2_win_addr, m2.addr);
        chk("d2_win_data", d2_win_data, m2.data);
      end
    end
    if (resetn && d2_done) d2_done_cnt++;
  end

  task automatic push1(input int n);
    win_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = ADDR_W'(centre_addr(i, W1));
      e.data = exp_data(centre_addr(i, W1), W1, H1);
      q1.push_back(e);
    end
  endtask

  task automatic push2(input int n);
    win_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = ADDR_W'(centre_addr(i, W2));
      e.data = exp_data(centre_addr(i, W2), W2, H2);
      q2.push_back(e);
    end
  endtask

  task automatic chk_rst1(input string pfx);
    chk({pfx, "_busy"}, d1_busy, 1'b0);
    chk({pfx, "_done"}, d1_done, 1'b0);
    chk({pfx, "_win_valid"}, d1_win_valid, 1'b0);
    chk({pfx, "_rd_en"}, d1_rd_en, 1'b0);
    chk({pfx, "_refAddr"}, d1_ref, '0);
    chk({pfx, "_regAddr"}, d1_reg, '0);
    chk({pfx, "_win_data"}, d1_win_data, '0);
    chk({pfx, "_win_addr"}, d1_win_addr, '0);
  endtask

  // ---------------- directed sequence ----------------
  logic [71:0]       snap_data;
  logic [ADDR_W-1:0] snap_addr;
  int  lat;
  bit  seen, stable, any_rd, stale;

  initial begin
    // Reset state
    resetn = 1'b0;
    tick(3);
    @(negedge clk);
    chk_rst1("rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(2);

    // First window latency, content and backpressure
    push1(200);
    d1_start = 1'b1;
    tick(1);
    d1_start = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (d1_win_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("first_valid_latency", lat, 10 + RD_LAT);
    snap_data = d1_win_data;
    snap_addr = d1_win_addr;
    chk("first_win_addr", snap_addr, BZ ? 0 : 181);
    chk("first_win_data", snap_data,
        BZ ? 72'hB5_B4_00_01_00_00_00_00_00 : 72'h6A_69_68_B6_B4_02_01_00_B5);
    @(posedge clk); #1;
    stable = 1'b1;
    any_rd = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!d1_win_valid || d1_win_data !== snap_data || d1_win_addr !== snap_addr) stable = 1'b0;
      if (d1_rd_en) any_rd = 1'b1;
      @(posedge clk); #1;
    end
    chk("stall_stable", stable, 1'b1);
    chk("stall_no_rd_en", any_rd, 1'b0);
    chk("stall_no_xfer", d1_xfer, 0);
    d1_ready = 1'b1;
    tick(1);
    @(negedge clk);
    chk("xfer_on_first_ready", d1_xfer, 1);
    chk("after_xfer_valid", d1_win_valid, 1'b0);

    // start while busy is ignored; scoreboard keeps the sequence
    tick(40);
    d1_start = 1'b1;
    tick(1);
    d1_start = 1'b0;

    // Row wrap
    for (int c = 0; c < 4000 && d1_xfer < 181; c++) tick(1);
    chk("wrap_reached", d1_xfer >= 181, 1'b1);
    chk("row_wrap_next_addr", d1_wrap_next, BZ ? W1 : 2 * W1 + 1);

    // Reset in the middle of FETCH
    d1_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (d1_reg == 4'd4) seen = 1'b1;
    end
    chk("mid_fetch_found", seen, 1'b1);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk_rst1("midrst");
    stale = 1'b0;
    repeat (RD_LAT + 4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (d1_win_data !== '0 || d1_win_valid || d1_busy || d1_rd_en) stale = 1'b1;
    end
    chk("no_stale_capture", stale, 1'b0);
    q1.delete();
    d1_xfer = 0;
    push1(3);
    @(posedge clk); #1;
    d1_ready = 1'b1;
    d1_start = 1'b1;
    tick(1);
    d1_start = 1'b0;
    for (int c = 0; c < 200 && d1_xfer < 3; c++) tick(1);
    chk("restart_xfers", d1_xfer >= 3, 1'b1);
    chk("restart_queue_empty", q1.size(), 0);
    d1_ready = 1'b0;

    // Whole small frame: count, last centre, single done pulse
    push2(n_windows(W2, H2));
    d2_ready = 1'b1;
    d2_start = 1'b1;
    tick(1);
    d2_start = 1'b0;
    tick(30);
    d2_start = 1'b1;
    tick(1);
    d2_start = 1'b0;
    for (int c = 0; c < n_windows(W2, H2) * 14 + 200 && d2_done_cnt == 0; c++) tick(1);
    chk("d2_done_seen", d2_done_cnt >= 1, 1'b1);
    tick(20);
    chk("d2_window_count", d2_xfer, n_windows(W2, H2));
    chk("d2_done_pulses", d2_done_cnt, 1);
    chk("d2_last_addr", d2_last, BZ ? W2 * H2 - 1 : (H2 - 2) * W2 + W2 - 2);
    chk("d2_busy_after_done", d2_busy, 1'b0);
    chk("d2_queue_empty", q2.size(), 0);
    chk("d1_oob_reads", d1_oob, 0);
    chk("d2_oob_reads", d2_oob, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
